serial_adder_ctrl: RTL and testbench

Bit-serial adder controller: accepts two WIDTH-bit operands through a start/ready handshake and sequences one full_adder bit slice LSB-first, one bit per clock. A carry flip-flop links the bits, and the result shifts into a sum register. It presents the sum and carry-out through a valid/ack handshake. It sits between a register-file or bus front end and the single-bit full_adder datapath, so one 1-bit adder can serve any operand width.

---
 rtl/serial_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: a single full_adder slice is sequenced LSB-first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the sub_i port and a subtract mode (a_i - b_i).
`timescale 1ns/1ps

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub_i,
`endif
   output logic             ready_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] s_o,
   output logic             c_o,
   output logic             valid_o,
   input  logic             ack_i
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   a_sr, b_sr, s_sr;
   logic [CNT_W-1:0]   cnt;
   logic               cy, c_q;
   logic               fa_sum, fa_cout;
   logic               accept, last_bit;
   logic [WIDTH-1:0]   b_load;
   logic               cy_load;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction is a + ~b + 1; the carry-out then reads as "no borrow".
   assign b_load  = sub_i ? ~b_i : b_i;
   assign cy_load = sub_i ? 1'b1 : c_i;
`else
   assign b_load  = b_i;
   assign cy_load = c_i;
`endif

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (cy),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // NOTE: state and datapath registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path leaves a value unassigned (no latch).
   always_comb begin
      state_nxt = state;
      ready_o   = 1'b0;
      busy_o    = 1'b0;
      valid_o   = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (start_i) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy_o = 1'b1;
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            valid_o = 1'b1;
            if (ack_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the whole datapath is reset so an aborted add leaves no stale sum or carry visible.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_sr <= '0;
         b_sr <= '0;
         s_sr <= '0;
         cy   <= 1'b0;
         c_q  <= 1'b0;
         cnt  <= '0;
      end else if (accept) begin
         a_sr <= a_i;
         b_sr <= b_load;
         cy   <= cy_load;
         s_sr <= '0;
         c_q  <= 1'b0;
         cnt  <= '0;
      end else if (state == RUN) begin
         s_sr <= {fa_sum, s_sr[WIDTH-1:1]};
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         cy   <= fa_cout;
         cnt  <= cnt + CNT_W'(1);
         if (last_bit) c_q <= fa_cout;
      end
   end

   assign s_o = s_sr;
   assign c_o = c_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: driver pushes reference results, monitor pops on valid_o.
// Builds with or without SERIAL_ADDER_SUB_EN to match the RTL.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;
   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH:0] res;
      int             acc;
   } exp_t;

   logic             clk, rst_ni, start_i, c_i, ack_i;
   logic             ready_o, busy_o, c_o, valid_o;
   logic [WIDTH-1:0] a_i, b_i, s_o;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub_i;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   exp_t cur;
   bit   have_cur = 0;
   bit   prev_valid = 0;
   bit   ack_hold = 0;
   int   ack_max = 0;
   int   wait_left = 0;

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .start_i (start_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .c_i     (c_i),
`ifdef SERIAL_ADDER_SUB_EN
      .sub_i   (sub_i),
`endif
      .ready_o (ready_o),
      .busy_o  (busy_o),
      .s_o     (s_o),
      .c_o     (c_o),
      .valid_o (valid_o),
      .ack_i   (ack_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic c, input logic sub);
      longint r;
      if (sub) begin
         r = longint'(a) - longint'(b);
         return {(a >= b), r[WIDTH-1:0]};
      end
      r = longint'(a) + longint'(b) + longint'(c);
      return r[WIDTH:0];
   endfunction

   task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic sub);
      int n = 0;
      @(negedge clk);
      while (!ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: ready_o=%0b, required 1", ready_o);
         return;
      end
      a_i = a;
      b_i = b;
      c_i = c;
`ifdef SERIAL_ADDER_SUB_EN
      sub_i = sub;
`endif
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      sb.push_back('{res: ref_model(a, b, c, sub), acc: cyc});
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || !ready_o) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || !ready_o) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: pending=%0d ready_o=%0b, required 0 and 1", sb.size(), ready_o);
      end
   endtask

   // Consumer: acks valid results after a random 0..ack_max cycle delay unless held off.
   initial begin
      ack_i = 1'b0;
      forever begin
         @(negedge clk);
         if (!valid_o) begin
            ack_i     = 1'b0;
            wait_left = $urandom_range(ack_max, 0);
         end else if (ack_hold) begin
            ack_i = 1'b0;
         end else if (wait_left == 0) begin
            ack_i = 1'b1;
         end else begin
            wait_left--;
         end
      end
   end

   // Monitor: pops on each new result, checks latency, then checks the value every cycle it is held.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            prev_valid = 1'b0;
            have_cur   = 1'b0;
         end else begin
            if (valid_o && !prev_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  have_cur = 1'b0;
                  $display("FAIL unexpected_valid: valid_o=1 with no add outstanding, s_o=0x%0h", s_o);
               end else begin
                  cur      = sb.pop_front();
                  have_cur = 1'b1;
                  check("latency", 32'(cyc - cur.acc), 32'(WIDTH));
               end
            end
            if (valid_o && have_cur) check("result", 32'({c_o, s_o}), 32'(cur.res));
            prev_valid = valid_o;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni  = 1'b0;
      start_i = 1'b0;
      a_i     = '0;
      b_i     = '0;
      c_i     = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_i   = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_s", 32'(s_o), 32'd0);
      check("rst_c", 32'(c_o), 32'd0);
      rst_ni = 1'b1;

      // Basic add and carry corners.
      ack_max = 0;
      do_add(8'h5A, 8'h3C, 1'b0, 1'b0);
      @(negedge clk);
      check("run_busy", 32'(busy_o), 32'd1);
      check("run_ready", 32'(ready_o), 32'd0);
      wait_drain();
      do_add(8'hFF, 8'h01, 1'b0, 1'b0);
      wait_drain();
      do_add(8'hFF, 8'h00, 1'b1, 1'b0);
      wait_drain();

      // Back-pressure: result held while new starts are ignored; start coinciding with ack is not taken.
      ack_hold = 1'b1;
      do_add(8'h12, 8'h34, 1'b0, 1'b0);
      for (int i = 0; i < 50 && !valid_o; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         a_i     = 8'($urandom);
         b_i     = 8'($urandom);
         c_i     = 1'($urandom);
         start_i = 1'b1;
         @(negedge clk);
         check("bp_ready", 32'(ready_o), 32'd0);
         check("bp_valid", 32'(valid_o), 32'd1);
      end
      @(posedge clk);
      #1;
      a_i      = 8'h77;
      b_i      = 8'h22;
      c_i      = 1'b1;
      ack_hold = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ack_start_ready", 32'(ready_o), 32'd1);
      check("ack_start_valid", 32'(valid_o), 32'd0);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      sb.push_back('{res: ref_model(8'h77, 8'h22, 1'b1, 1'b0), acc: cyc});
      wait_drain();
      repeat (12) @(negedge clk);

      // Reset in the middle of a run.
      do_add(8'hAA, 8'h55, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      check("abort_ready", 32'(ready_o), 32'd1);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_valid", 32'(valid_o), 32'd0);
      check("abort_s", 32'(s_o), 32'd0);
      check("abort_c", 32'(c_o), 32'd0);
      void'(sb.pop_back());
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(ready_o), 32'd1);
      do_add(8'h01, 8'h01, 1'b0, 1'b0);
      wait_drain();

`ifdef SERIAL_ADDER_SUB_EN
      do_add(8'h10, 8'h01, 1'b0, 1'b1);
      wait_drain();
      do_add(8'h01, 8'h02, 1'b1, 1'b1);
      wait_drain();
`endif

      // Random operands with random ack delay.
      ack_max = 3;
      for (int i = 0; i < 1000; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
         do_add(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
`else
         do_add(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
`endif
      end
      wait_drain();
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
